uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: BUSY_WAIT, default 8, cycles allowed between tx_start and tx_busy rising before timeout (range 1..255).
REQ-002 Port: clk  input  1  system clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  input  4  per-requester byte valid, requester i on bit i.
REQ-005 Port: req_data  input  32  per-requester byte, requester i on bits [8i+7:8i].
REQ-006 Port: req_last  input  4  per-requester last-byte-of-packet marker.
REQ-007 Port: req_ready  output  4  per-requester accept; byte transfers on the rising edge where valid[i] and ready[i] are both high.
REQ-008 Port: tx_start  output  1  one-cycle launch pulse to the UART transmitter.
REQ-009 Port: tx_data  output  8  byte to transmit, stable from the launch cycle through end of WAIT_DONE.
REQ-010 Port: tx_busy  input  1  transmitter busy; high from start bit through stop bit.
REQ-011 Port: grant_id  output  2  index of the requester currently or most recently granted.
REQ-012 Port: byte_done  output  1  one-cycle pulse when the transmitter finishes a granted byte.
REQ-013 Port: err_timeout  output  1  sticky flag: tx_busy failed to rise within BUSY_WAIT cycles.

Function
REQ-014 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE; one state per cycle minimum.
REQ-015 IDLE: when tx_busy=0 and any req_valid=1, the winner's req_ready is asserted combinationally in that same cycle, req_data[winner] latched into tx_data, grant_id=winner, next state LAUNCH.
REQ-016 IDLE with tx_busy=1: no req_ready asserted, stay IDLE.
REQ-017 Arbitration: round-robin; search starts at (last_grant+1) mod 4 and ascends with wrap; last_grant updates at acceptance.
REQ-018 At most one req_ready bit high in any cycle; req_ready is 0 in all states except IDLE.
REQ-019 LAUNCH: tx_start=1 for exactly this one cycle; next state WAIT_BUSY; wait counter cleared.
REQ-020 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; otherwise counter increments; when counter reaches BUSY_WAIT -> err_timeout set to 1, state IDLE, no byte_done.
REQ-021 WAIT_DONE: tx_busy=0 -> byte_done=1 for one cycle, state IDLE; acceptance of the next byte is possible no earlier than the cycle after byte_done.
REQ-022 Latency: acceptance edge -> tx_start high in the next cycle (1 cycle).
REQ-023 tx_data and grant_id hold their value until the next acceptance.
REQ-024 err_timeout is cleared only by reset.

Reset
REQ-025 rst=1 forces, asynchronously: state IDLE, tx_start=0, tx_data=0, grant_id=0, byte_done=0, err_timeout=0, wait counter=0, last_grant=3 (first winner search starts at 0), packet lock cleared.
REQ-026 Reset asserted mid-transfer aborts the byte with no byte_done; after release the block waits in IDLE for tx_busy=0 before granting.

Configuration
REQ-027 Macro UART_ARB_PKT_LOCK_EN: when defined, accepting a byte with req_last=0 locks arbitration to that requester; in IDLE only that requester can be granted until a byte with req_last=1 is accepted; a timeout releases the lock.
REQ-028 Without UART_ARB_PKT_LOCK_EN: req_last is ignored; every byte is arbitrated independently per REQ-017.

Verification
REQ-029 Single request: req_valid=0001, data 0x55, tx_busy rises 2 cycles after tx_start and stays high 160 cycles -> one req_ready[0] pulse, tx_start one cycle later, tx_data=0x55, byte_done once after tx_busy falls.
REQ-030 Round-robin: req_valid=1111 held, data 0xA0..0xA3 -> tx_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0; grant_id 0,1,2,3,0.
REQ-031 Timeout: BUSY_WAIT=8, tx_busy held 0 -> err_timeout=1 after 8 WAIT_BUSY cycles, no byte_done, next request still granted.
REQ-032 Packet lock (macro defined): req 2 sends 0x11(last=0),0x22(last=1) while req 0 valid -> order 0x11,0x22, then req 0; without macro -> 0x11, req 0 byte, 0x22.
REQ-033 Reset mid-WAIT_DONE -> all outputs at reset values the same cycle, no byte_done; tx_busy held 1 after release -> no grant until it falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding bytes from 4 requesters to one UART transmitter
// Optional packet lock: define UART_ARB_PKT_LOCK_EN.
module uart_tx_arbiter #(
    parameter int BUSY_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [1:0]  grant_id,
    output logic        byte_done,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  wait_cnt;
    logic [1:0]  last_grant;
    logic [1:0]  winner;
    logic [1:0]  idx;
    logic        found;
    logic [3:0]  eligible;
    logic        accept;
    logic        timeout;

`ifdef UART_ARB_PKT_LOCK_EN
    logic       lock_active;
    logic [1:0] lock_id;

    always_comb begin
        eligible = req_valid;
        if (lock_active)
            eligible = req_valid & (4'b0001 << lock_id);
    end

    // A byte without its last marker pins arbitration to its sender; a timeout frees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_active <= 1'b0;
            lock_id     <= 2'd0;
        end else if (accept) begin
            lock_active <= ~req_last[winner];
            lock_id     <= winner;
        end else if (timeout) begin
            lock_active <= 1'b0;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign eligible    = req_valid;
`endif

    // Search starts one past the previous winner and wraps.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign accept  = (state == IDLE) && !tx_busy && found;
    assign timeout = (state == WAIT_BUSY) && !tx_busy && (wait_cnt == 8'(BUSY_WAIT - 1));

    always_comb begin
        state_next = state;
        req_ready  = 4'b0000;
        tx_start   = 1'b0;
        byte_done  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready  = 4'b0001 << winner;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start   = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy)
                    state_next = WAIT_DONE;
                else if (timeout)
                    state_next = IDLE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            tx_data     <= 8'h00;
            grant_id    <= 2'd0;
            last_grant  <= 2'd3;
            err_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                tx_data    <= req_data[{winner, 3'b000} +: 8];
                grant_id   <= winner;
                last_grant <= winner;
            end
            if (state == LAUNCH)
                wait_cnt <= 8'd0;
            else if ((state == WAIT_BUSY) && !tx_busy && !timeout)
                wait_cnt <= wait_cnt + 8'd1;
            if (timeout)
                err_timeout <= 1'b1;
        end
    end

endmodule
